// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: local types for the shared-ALU arbiter.
// Defines the per-requester response-slot state and the datapath width.
package alu_arbiter_pkg;

  localparam int unsigned DataW = 32;

  typedef enum logic {
    SlotEmpty = 1'b0,
    SlotFull  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/mrv32_pkg.sv
// mrv32_pkg: shared core constants.
// Holds the ALU operation encodings and the aluop width. Every unit that drives or decodes
// an aluop uses these values.
package mrv32_pkg;

  localparam int unsigned ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 4'd10;  // LUI-style copy of op2

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between NREQ requesters and the arbiter.
// Signals:
//   req_valid/req_ready : per-requester request handshake
//   req_op1/op2/aluop   : operation presented by each requester
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_result          : result held in each response slot
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int unsigned NREQ = 2
) ();

  logic [NREQ-1:0]                         req_valid;
  logic [NREQ-1:0]                         req_ready;
  logic [NREQ-1:0][31:0]                   req_op1;
  logic [NREQ-1:0][31:0]                   req_op2;
  logic [NREQ-1:0][mrv32_pkg::ALU_OP_W-1:0] req_aluop;
  logic [NREQ-1:0]                         rsp_valid;
  logic [NREQ-1:0]                         rsp_ready;
  logic [NREQ-1:0][31:0]                   rsp_result;

  modport master (
    output req_valid, req_op1, req_op2, req_aluop, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_aluop, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );

endinterface

// File: rtl/alu.sv
// alu: purely combinational 32-bit integer ALU.
// Ports:
//   op1_i, op2_i : operands
//   aluop_i      : operation (mrv32_pkg ALU_* encoding)
//   result_o     : result; unsupported encodings yield 0
module alu
  import mrv32_pkg::*;
(
  input  logic [31:0]         op1_i,
  input  logic [31:0]         op2_i,
  input  logic [ALU_OP_W-1:0] aluop_i,
  output logic [31:0]         result_o
);

  always_comb begin
    result_o = '0;
    case (aluop_i)
      ALU_ADD:    result_o = op1_i + op2_i;
      ALU_SUB:    result_o = op1_i - op2_i;
      ALU_SLL:    result_o = op1_i << op2_i[4:0];
      ALU_SLT:    result_o = {31'b0, $signed(op1_i) < $signed(op2_i)};
      ALU_SLTU:   result_o = {31'b0, op1_i < op2_i};
      ALU_XOR:    result_o = op1_i ^ op2_i;
      ALU_SRL:    result_o = op1_i >> op2_i[4:0];
      ALU_SRA:    result_o = $signed(op1_i) >>> op2_i[4:0];
      ALU_OR:     result_o = op1_i | op2_i;
      ALU_AND:    result_o = op1_i & op2_i;
      ALU_PASS_B: result_o = op2_i;
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between NREQ requesters.
// Round-robin grant, at most one accepted operation per cycle. Each requester owns a
// one-entry response slot written at the accept edge, so results appear one cycle later
// and can be back-pressured per requester.
// Ports:
//   clk   : clock, all flops on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_arbiter_if slave modport (request and response handshakes)
module alu_arbiter
  import mrv32_pkg::*;
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = $clog2(NREQ > 1 ? NREQ : 2)
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [PTR_W-1:0] LastIdx = PTR_W'(NREQ - 1);

  slot_state_e                 slot_q [NREQ];
  slot_state_e                 slot_d [NREQ];
  logic [NREQ-1:0][DataW-1:0]  result_q, result_d;
  logic [PTR_W-1:0]            last_q, last_d;

  logic [NREQ-1:0]   full, slot_free, elig, grant;
  logic [NREQ-1:0]   rot_elig, rot_pick;
  logic [2*NREQ-1:0] elig_dbl, pick_dbl;
  logic [PTR_W-1:0]  start, gidx;

  logic [DataW-1:0]    alu_a, alu_b, alu_y;
  logic [ALU_OP_W-1:0] alu_op;

  // Round-robin grant: rotate eligibility so the search start sits at bit 0, keep the
  // lowest set bit, then rotate the one-hot back into requester order.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      full[i] = (slot_q[i] == SlotFull);
    end
    // A slot being drained this cycle can be refilled in the same cycle.
    slot_free = ~full | bus.rsp_ready;
    elig      = bus.req_valid & slot_free;
    start     = (last_q == LastIdx) ? '0 : last_q + PTR_W'(1);
    elig_dbl  = {elig, elig} >> start;
    rot_elig  = elig_dbl[NREQ-1:0];
    rot_pick  = rot_elig & (~rot_elig + NREQ'(1));
    pick_dbl  = {rot_pick, rot_pick} << start;
    grant     = pick_dbl[2*NREQ-1:NREQ];
  end

  // One-hot grant steers the shared ALU inputs and yields the pointer index.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    gidx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        alu_a  = bus.req_op1[i];
        alu_b  = bus.req_op2[i];
        alu_op = bus.req_aluop[i];
        gidx   = PTR_W'(i);
      end
    end
  end

  alu u_alu (
    .op1_i    (alu_a),
    .op2_i    (alu_b),
    .aluop_i  (alu_op),
    .result_o (alu_y)
  );

  // Per-slot EMPTY/FULL machine; result only written on accept.
  always_comb begin
    slot_d   = slot_q;
    result_d = result_q;
    last_d   = (|grant) ? gidx : last_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        result_d[i] = alu_y;
      end
      unique case (slot_q[i])
        SlotEmpty: if (grant[i]) slot_d[i] = SlotFull;
        SlotFull:  if (bus.rsp_ready[i] && !grant[i]) slot_d[i] = SlotEmpty;
        default:   slot_d[i] = SlotEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        slot_q[i] <= SlotEmpty;
      end
      result_q <= '0;
      last_q   <= LastIdx;
    end else begin
      slot_q   <= slot_d;
      result_q <= result_d;
      last_q   <= last_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = full;
  assign bus.rsp_result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios followed by a randomized phase, all compared against
// a behavioural model of the arbiter (slot flags, result array, last-grant index).
module tb_alu_arbiter;
  import mrv32_pkg::*;

  localparam int unsigned NREQ = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          mv [NREQ];
  logic [31:0] mr [NREQ];
  int          mlast;
  logic [NREQ-1:0] seen_grant;
  logic [NREQ-1:0] model_grant;
  bit          pend [NREQ];

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_SLL:    return a << sh;
      ALU_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return a >> sh;
      ALU_SRA:    return 32'($signed(a) >>> sh);
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_PASS_B: return b;
      default:    return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Search from the requester after the last grant, wrapping around.
  function automatic logic [NREQ-1:0] ref_grant();
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (mlast + k) % NREQ;
      if (bus.req_valid[i] && (!mv[i] || bus.rsp_ready[i])) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
    end
    mlast = NREQ - 1;
  endtask

  task automatic set_req(input int i, input logic [ALU_OP_W-1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_aluop[i] = op;
    bus.req_op1[i]   = a;
    bus.req_op2[i]   = b;
  endtask

  // Inputs are set at posedge+1; compare at posedge+3, then advance the model at the edge.
  task automatic tick();
    logic [NREQ-1:0] g;
    #2;
    g           = ref_grant();
    model_grant = g;
    seen_grant  = bus.req_ready;
    check("req_ready", 32'(bus.req_ready), 32'(g));
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("rsp_valid[%0d]", i), 32'(bus.rsp_valid[i]), 32'(mv[i]));
      check($sformatf("rsp_result[%0d]", i), bus.rsp_result[i], mr[i]);
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          mv[i] = 1'b1;
          mr[i] = alu_ref(bus.req_aluop[i], bus.req_op1[i], bus.req_op2[i]);
          mlast = i;
        end else if (mv[i] && bus.rsp_ready[i]) begin
          mv[i] = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, ALU_ADD, 32'd1, 32'd1);
    @(posedge clk);
    #1;

    // Reset held 3 cycles with all requesters valid
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("first_grant", 32'(seen_grant), 32'b01);

    // Single-op latency on requester 1
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b00;
    set_req(1, ALU_SUB, 32'd5, 32'd7);
    tick();
    check("lat_grant", 32'(seen_grant), 32'b10);
    check("lat_valid", 32'(bus.rsp_valid[1]), 32'd1);
    check("lat_result", bus.rsp_result[1], 32'hFFFF_FFFE);
    bus.req_valid = 2'b00;
    tick();
    check("lat_hold", bus.rsp_result[1], 32'hFFFF_FFFE);
    bus.rsp_ready = 2'b11;
    tick();

    // Round-robin with both always valid
    bus.req_valid = 2'b11;
    set_req(0, ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A);
    set_req(1, ALU_SLL, 32'h0000_0003, 32'd4);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr_grant%0d", k), 32'(seen_grant), (k % 2 == 0) ? 32'b01 : 32'b10);
      check("rr_onehot", 32'($countones(seen_grant)), 32'd1);
    end

    // Backpressure on slot 0
    bus.req_valid = 2'b01;
    set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
    tick();
    check("bp_fill", bus.rsp_result[0], 32'hF800_0000);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b10;
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_grant", 32'(seen_grant), 32'b10);
      check("bp_hold", bus.rsp_result[0], 32'hF800_0000);
    end
    bus.rsp_ready = 2'b11;
    tick();
    check("bp_release", 32'(seen_grant), 32'b01);

    // Drain and refill slot 0 in the same cycle
    bus.req_valid = 2'b01;
    set_req(0, ALU_ADD, 32'd2, 32'd3);
    tick();
    check("dr_add", bus.rsp_result[0], 32'd5);
    bus.rsp_ready = 2'b01;
    set_req(0, ALU_SLTU, 32'd1, 32'd2);
    tick();
    check("dr_grant", 32'(seen_grant), 32'b01);
    check("dr_valid", 32'(bus.rsp_valid[0]), 32'd1);
    check("dr_result", bus.rsp_result[0], 32'd1);

    // Mid-operation reset with both slots full
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    tick();
    check("mr_full", 32'(bus.rsp_valid), 32'b11);
    rst_n = 1'b0;
    tick();
    check("mr_cleared", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mr_first_grant", 32'(seen_grant), 32'b01);

    // Randomized phase; operands held stable until accepted
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    tick();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_req(i, 4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
        end
        bus.req_valid[i] = pend[i];
        bus.rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (model_grant[i]) pend[i] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between `NREQ` requesters (e.g. the execute stage and a branch/address-generation unit) through valid/ready handshakes. Arbitration is round-robin with one accepted operation per cycle. Each requester has a one-entry registered response slot, so results appear one cycle after acceptance and can be back-pressured independently.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters; legal range 1..8.
- `PTR_W`, default `$clog2(NREQ > 1 ? NREQ : 2)`: width of the round-robin pointer; derived, not overridden.

Ports:
- `clk`  input  1: the only clock; every flop is on its rising edge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `req_valid`  input  [NREQ-1:0]: requester i presents an operation.
- `req_ready`  output  [NREQ-1:0]: requester i's operation is accepted this cycle.
- `req_op1`  input  [NREQ-1:0][31:0]: first operand per requester.
- `req_op2`  input  [NREQ-1:0][31:0]: second operand per requester.
- `req_aluop`  input  [NREQ-1:0][3:0]: operation per requester, encoded with the `mrv32_pkg` ALU_* values.
- `rsp_valid`  output  [NREQ-1:0]: response slot i holds a result.
- `rsp_ready`  input  [NREQ-1:0]: requester i consumes its result.
- `rsp_result`  output  [NREQ-1:0][31:0]: result held in slot i.

## Operation
Eligibility and grant:
- Requester i is eligible when `req_valid[i]` is high and slot i is free this cycle.
- Slot i is free when `!rsp_valid[i] || rsp_ready[i]`. Draining a slot and refilling it in the same cycle is allowed.
- Exactly one eligible requester is granted, or none if none is eligible.
- Priority is round-robin: search starts at `(last_grant+1) mod NREQ` and wraps.
- `req_ready` is one-hot or zero and equals the grant.
  - It depends combinationally on `req_valid` and `rsp_ready`.
  - It never depends on the operand or aluop values.

Execution:
- The granted requester's `op1`/`op2`/`aluop` drive the single `alu`.
- The ALU output is captured into slot g at the clock edge. `rsp_valid[g]` is then set.
- `last_grant` updates to g only on an accepted transfer. With no grant it holds.
- A slot clears when `rsp_valid & rsp_ready` and no new accept targets it in the same cycle.
- `rsp_result[i]` holds its value while `rsp_valid[i]` is high and not consumed.
- Unsupported aluop values return 0, per `alu`. The arbiter does not check encodings.

Requester obligations:
- Hold valid, operands and aluop stable until accepted.
- The arbiter does not check this.

Per-slot state machine:
- States are EMPTY and FULL.
- EMPTY -> FULL on accept.
- FULL -> EMPTY on consume without accept.
- FULL -> FULL on consume with accept, or on neither.

## Timing
- Reset values: `rsp_valid` = 0, all `rsp_result` = 0, `last_grant` = NREQ-1, so requester 0 has first priority.
- `req_ready` is combinational. During reset and in the first cycle after reset it follows the rules above; outputs are registered values only.
- Latency: accept at edge N, so `rsp_valid` is high and `rsp_result` is valid from edge N onward (the cycle after the accept cycle).
- Throughput is one operation per cycle in aggregate.
  - A single requester with `rsp_ready` held high sustains one operation per cycle.
- Fairness: a continuously valid requester with a free slot is granted within NREQ cycles.
- A requester whose slot is FULL with `rsp_ready` low is skipped. It does not block the others and does not consume a priority turn.
- Reset asserted mid-operation discards pending results, returns every slot to EMPTY and restores the pointer, all at that edge.
- NREQ=1: a single requester, grant = `req_valid & slot free`; the pointer is constant.

## Structure
- ALU_* encodings and the 4-bit aluop width come from `mrv32_pkg`.
- Add a shared `ALU_OP_W` = 4 constant to `mrv32_pkg` if it is missing.
- One sub-module: `alu`, instantiated once. No local copy of ALU logic.
- The round-robin grant (rotate, priority-pick, rotate back) stays inline. Do not create a separate module for it.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req_valid`=all ones. Required: `rsp_valid`=0 and `rsp_result`=0 throughout. In the first cycle after release requester 0 is granted; the other requesters' `req_ready` stays 0.
- **Single op latency:** requester 1 sends ALU_SUB, op1=5, op2=7, and is accepted at edge N. Required: from edge N, `rsp_valid[1]`=1 and `rsp_result[1]`=32'hFFFF_FFFE.
- **Round-robin:** both requesters valid every cycle with `rsp_ready`=all ones. Required: grants alternate 0,1,0,1 for 8 cycles, with exactly one `req_ready` high per cycle.
- **Backpressure:**
  - Fill slot 0 with ALU_SRA, op1=32'h8000_0000, op2=4. Hold `rsp_ready[0]`=0 and keep both requesters valid.
  - Required: `rsp_result[0]` stays 32'hF800_0000; requester 1 is granted every cycle; requester 0 is never granted until `rsp_ready[0]`=1.
- **Simultaneous drain and refill:**
  - Slot 0 is FULL with ALU_ADD 2+3=5. In the same cycle `rsp_ready[0]`=1 and requester 0 sends ALU_SLTU, op1=1, op2=2.
  - Required: `rsp_valid[0]` stays 1 and the next result is 1.
- **Mid-operation reset:** `rst_n` goes low for 1 cycle while both slots are FULL. Required: both `rsp_valid` bits are 0 after that edge, and the first post-reset grant goes to requester 0.
